pc_fetch_sequencer: RTL
=======================

// Module: pc_fetch_sequencer
// PURPOSE
//  Program-counter register and instruction-fetch sequencer; other end of the PC+4 adder loop.
//  Drives PCResult to the adder and consumes PCAddResult as the sequential next PC.
//  Applies branch/jump redirects and runs a req/ack fetch from instruction memory.
//  Feeds the IF/ID register with a valid/stall handshake.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC value loaded on reset
// PORTS
//  Clk           in   1   system clock, all state updates on posedge
//  Reset         in   1   synchronous, active-low reset
//  PCAddResult   in   32  PCResult + 4 from the adder; this block does not check it
//  BranchTaken   in   1   redirect to BranchTarget this cycle
//  BranchTarget  in   32  branch destination
//  JumpTaken     in   1   redirect to JumpTarget this cycle; priority over branch
//  JumpTarget    in   32  jump destination
//  Stall         in   1   IF/ID cannot accept; hold Instr/InstrPC/InstrValid
//  IMemAck       in   1   memory accepted IMemAddr; IMemData valid the same cycle
//  IMemData      in   32  instruction word
//  PCResult      out  32  current PC, to the adder
//  IMemReq       out  1   fetch request
//  IMemAddr      out  32  fetch address; stable while IMemReq=1 and !IMemAck
//  Instr         out  32  fetched instruction to IF/ID
//  InstrPC       out  32  PC of Instr
//  InstrValid    out  1   Instr is valid
//  AlignFault    out  1   sticky misaligned-target flag; tied 0 unless PC_ALIGN_CHECK_EN
// BEHAVIOUR
//  Reset (Reset==0 at posedge), highest priority, in any state, aborts an outstanding fetch:
//   PCResult=RESET_PC, IMemAddr=RESET_PC, IMemReq=0, Instr=0, InstrPC=0,
//   InstrValid=0, AlignFault=0, state=BOOT.
//  Memory protocol: once raised, IMemReq stays 1 with IMemAddr held until IMemAck.
//   A zero-wait ack in the same cycle as the request is legal.
//  Slot free = !InstrValid || !Stall. If InstrValid && !Stall with no load, InstrValid<=0 (consumed).
//  Next-PC priority: JumpTaken > BranchTaken > PCAddResult. A redirect overrides Stall.
//  32-bit arithmetic wraps 0xFFFF_FFFC -> 0x0000_0000; the adder supplies it, this block passes it through.
//  FSM states: BOOT, FETCH, DROP (+TRAP with the macro).
//  BOOT: one cycle, IMemReq=0, then -> FETCH. A redirect in BOOT still loads PCResult.
//  FETCH: IMemReq = slot free OR request already outstanding; IMemAddr=PCResult when newly raised.
//   Ack, no redirect: Instr<=IMemData, InstrPC<=IMemAddr, InstrValid<=1, PCResult<=PCAddResult.
//   Redirect, no request outstanding: PCResult<=target, InstrValid<=0, stay FETCH.
//   Redirect with ack in the same cycle: discard data, PCResult<=target, InstrValid<=0, stay FETCH.
//   Redirect, request outstanding without ack: PCResult<=target, InstrValid<=0, -> DROP.
//  DROP: keep IMemReq=1 and the old IMemAddr. On ack, discard data -> FETCH.
//   A further redirect in DROP updates PCResult (newest wins) and stays in DROP.
//  Fetch latency: request -> InstrValid is 1 cycle after IMemAck. Steady-state throughput is 1 instr/cycle with zero-wait memory.
// CONFIGURATION
//  PC_ALIGN_CHECK_EN defined:
//   A redirect target with [1:0]!=0 loads PCResult unmodified, sets AlignFault=1,
//    clears InstrValid, and -> TRAP.
//   TRAP first completes any outstanding request (data discarded), then IMemReq=0.
//   TRAP is left only by reset.
//  PC_ALIGN_CHECK_EN undefined: target[1:0] forced to 2'b00, AlignFault tied 0, no TRAP state.
// TESTING
//  Reset, zero-wait ack each cycle, adder model -> InstrPC 0,4,8,12 on consecutive cycles, InstrValid held 1.
//  Stall=1 for 3 cycles with InstrValid=1 -> Instr/InstrPC frozen, IMemReq=0, PCResult unchanged.
//  Ack delayed 3 cycles -> IMemAddr stable at 0x10 throughout; Instr=IMemData one cycle after ack.
//  Branch to 0x100 while a 0x20 request is outstanding -> DROP; 0x20 data discarded; next fetch at 0x100.
//  JumpTaken(0x200) and BranchTaken(0x300) in the same cycle -> PCResult=0x200.
//  Macro on, BranchTarget=0x102 -> AlignFault=1, IMemReq=0 after the drain. Macro off -> fetch at 0x100.

Source files
------------

// File: rtl/pc_fetch_sequencer.sv
// ---------------------------------------------------------------------------
// pc_fetch_sequencer
//
// Program-counter register and instruction-fetch sequencer. This block holds
// the PC, sends it to the external PC+4 adder, and takes the adder result back
// as the sequential next PC. Branch and jump redirects replace that next PC.
// The block runs a req/ack fetch from instruction memory and hands each
// fetched word to the IF/ID register through a valid/stall handshake.
//
// Optional build macro:
//   PC_ALIGN_CHECK_EN - a redirect target whose low two bits are not zero sets
//                       a sticky AlignFault. The sequencer then drains any
//                       outstanding fetch and parks in TRAP until reset.
//                       Without the macro, the low two bits of the target are
//                       cleared and AlignFault stays 0.
//
// Parameters:
//   RESET_PC      PC value loaded on reset
//
// Ports:
//   Clk           in   1   system clock, posedge
//   Reset         in   1   synchronous active-low reset
//   PCAddResult   in   32  PCResult + 4 from the adder
//   BranchTaken   in   1   redirect to BranchTarget this cycle
//   BranchTarget  in   32  branch destination
//   JumpTaken     in   1   redirect to JumpTarget, wins over branch
//   JumpTarget    in   32  jump destination
//   Stall         in   1   IF/ID cannot accept a new instruction
//   IMemAck       in   1   memory accepted IMemAddr, IMemData valid now
//   IMemData      in   32  instruction word
//   PCResult      out  32  current PC, to the adder
//   IMemReq       out  1   fetch request
//   IMemAddr      out  32  fetch address, held until acknowledged
//   Instr         out  32  fetched instruction
//   InstrPC       out  32  PC of Instr
//   InstrValid    out  1   Instr is valid
//   AlignFault    out  1   sticky misaligned-redirect flag
// ---------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] PCAddResult,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    input  logic        JumpTaken,
    input  logic [31:0] JumpTarget,
    input  logic        Stall,
    input  logic        IMemAck,
    input  logic [31:0] IMemData,
    output logic [31:0] PCResult,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    output logic [31:0] Instr,
    output logic [31:0] InstrPC,
    output logic        InstrValid,
    output logic        AlignFault
);

    localparam logic [1:0] ST_BOOT  = 2'd0;
    localparam logic [1:0] ST_FETCH = 2'd1;
    localparam logic [1:0] ST_DROP  = 2'd2;
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [1:0] ST_TRAP  = 2'd3;
`endif

    logic [1:0]  state;
    logic        req_pending;
    logic [31:0] req_addr;
    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] target;
    logic        misaligned;
    logic        slot_free;

    // Redirect selection: a jump always beats a branch.
    assign redirect   = JumpTaken | BranchTaken;
    assign raw_target = JumpTaken ? JumpTarget : BranchTarget;

`ifdef PC_ALIGN_CHECK_EN
    assign target     = raw_target;
    assign misaligned = redirect && (raw_target[1:0] != 2'b00);
`else
    assign target     = raw_target & 32'hFFFF_FFFC;
    assign misaligned = 1'b0;
    assign AlignFault = 1'b0;
`endif

    // IF/ID can accept a new word when it is empty or is draining this cycle.
    assign slot_free = !InstrValid || !Stall;

    // Request generation. A request that has been raised stays up, with its
    // address frozen in req_addr, until memory acknowledges it. A new request
    // shows the live PC so a zero-wait ack can complete in the same cycle.
    always_comb begin
        IMemReq = 1'b0;
        case (state)
            ST_FETCH: IMemReq = slot_free || req_pending;
            ST_DROP:  IMemReq = req_pending;
`ifdef PC_ALIGN_CHECK_EN
            ST_TRAP:  IMemReq = req_pending;
`endif
            default:  IMemReq = 1'b0;
        endcase
        IMemAddr = req_pending ? req_addr : PCResult;
    end

    // Outstanding-request tracker. It remembers that a request went out
    // without an ack, and the address that request used.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            req_pending <= 1'b0;
            req_addr    <= RESET_PC;
        end else begin
            req_pending <= IMemReq && !IMemAck;
            if (IMemReq)
                req_addr <= IMemAddr;
        end
    end

    // Main sequencer: PC update, FSM, and the IF/ID output register.
    // A word sitting in IF/ID is consumed when Stall is low. A new load in
    // the same cycle overrides that clear. A redirect always clears
    // InstrValid, because the word in flight or in IF/ID is on the wrong path.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state      <= ST_BOOT;
            PCResult   <= RESET_PC;
            Instr      <= 32'h0;
            InstrPC    <= 32'h0;
            InstrValid <= 1'b0;
        end else begin
            if (InstrValid && !Stall)
                InstrValid <= 1'b0;

            case (state)
                ST_BOOT: begin
                    if (redirect)
                        PCResult <= target;
`ifdef PC_ALIGN_CHECK_EN
                    if (misaligned)
                        state <= ST_TRAP;
                    else
`endif
                    state <= ST_FETCH;
                end

                ST_FETCH: begin
                    if (redirect) begin
                        PCResult   <= target;
                        InstrValid <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
                        if (misaligned)
                            state <= ST_TRAP;
                        else
`endif
                        if (IMemReq && !IMemAck)
                            state <= ST_DROP;
                        else
                            state <= ST_FETCH;
                    end else if (IMemReq && IMemAck) begin
                        Instr      <= IMemData;
                        InstrPC    <= IMemAddr;
                        InstrValid <= 1'b1;
                        PCResult   <= PCAddResult;
                    end
                end

                // The old request must still finish on the bus, but its data
                // belongs to the wrong path and is thrown away. A further
                // redirect only moves the PC. The newest target wins.
                ST_DROP: begin
                    InstrValid <= 1'b0;
                    if (redirect)
                        PCResult <= target;
`ifdef PC_ALIGN_CHECK_EN
                    if (misaligned)
                        state <= ST_TRAP;
                    else
`endif
                    if (IMemAck)
                        state <= ST_FETCH;
                end

`ifdef PC_ALIGN_CHECK_EN
                // Parked after a misaligned redirect. The tracker drains any
                // outstanding request, and only reset leaves this state.
                ST_TRAP: begin
                    InstrValid <= 1'b0;
                end
`endif

                default: state <= ST_BOOT;
            endcase
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Sticky fault flag: set on any misaligned redirect, cleared only by reset.
    always_ff @(posedge Clk) begin
        if (!Reset)
            AlignFault <= 1'b0;
        else if (misaligned)
            AlignFault <= 1'b1;
    end
`endif

endmodule
